// File: rtl/mu0_control_pkg.sv
// Shared encodings for the MU0 sequencer: states, opcodes, ALU functions and the control vector.
package mu0_control_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] M_Y   = 2'b00;
    localparam logic [1:0] M_ADD = 2'b01;
    localparam logic [1:0] M_INC = 2'b10;
    localparam logic [1:0] M_SUB = 2'b11;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] m;
        logic       rd;
        logic       wr;
    } ctrl_t;

    // Opcodes 0..3 touch memory and wait on Mem_Ack.
    function automatic logic is_mem_op(input logic [3:0] f);
        return (f[3:2] == 2'b00);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] f);
        return f[3];
    endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational decode of state, opcode and flags into the MU0 datapath control vector.
module mu0_decode
    import mu0_control_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] f,
    input  logic       n,
    input  logic       z,
    input  logic       mem_ack,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.addr_sel = 1'b0;
                ctrl.rd       = 1'b1;
                ctrl.x_sel    = 1'b1;
                ctrl.m        = M_INC;
                ctrl.ir_en    = mem_ack;
                ctrl.pc_en    = mem_ack;
            end
            ST_EXEC: begin
                case (f)
                    OP_LDA: begin
                        ctrl.addr_sel = 1'b1;
                        ctrl.rd       = 1'b1;
                        ctrl.m        = M_Y;
                        ctrl.acc_en   = mem_ack;
                    end
                    OP_STA: begin
                        ctrl.addr_sel = 1'b1;
                        ctrl.wr       = 1'b1;
                    end
                    OP_ADD: begin
                        ctrl.addr_sel = 1'b1;
                        ctrl.rd       = 1'b1;
                        ctrl.m        = M_ADD;
                        ctrl.acc_en   = mem_ack;
                    end
                    OP_SUB: begin
                        ctrl.addr_sel = 1'b1;
                        ctrl.rd       = 1'b1;
                        ctrl.m        = M_SUB;
                        ctrl.acc_en   = mem_ack;
                    end
                    OP_JMP: begin
                        ctrl.y_sel = 1'b1;
                        ctrl.m     = M_Y;
                        ctrl.pc_en = 1'b1;
                    end
                    OP_JGE: begin
                        ctrl.y_sel = 1'b1;
                        ctrl.m     = M_Y;
                        ctrl.pc_en = ~n;
                    end
                    OP_JNE: begin
                        ctrl.y_sel = 1'b1;
                        ctrl.m     = M_Y;
                        ctrl.pc_en = ~z;
                    end
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 sequencer: FETCH/EXEC/HALT state register, halt/illegal flags and next-state logic.
//   state    | meaning
//   ST_FETCH | read instruction at PC, increment PC, wait for Mem_Ack
//   ST_EXEC  | execute IR opcode, memory ops wait for Mem_Ack
//   ST_HALT  | stopped after STP or illegal opcode, until Reset
module mu0_control
    import mu0_control_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Ack,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic [1:0] M,
    output logic       Rd,
    output logic       Wr,
    output logic       Halted,
    output logic       Illegal
);

    state_t state_q;
    state_t state_d;
    logic   halted_q;
    logic   illegal_q;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

    mu0_decode u_decode (
        .state   (state_q),
        .f       (F),
        .n       (N),
        .z       (Z),
        .mem_ack (Mem_Ack),
        .ctrl    (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (Mem_Ack) state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_mem_op(F)) begin
                    if (Mem_Ack) state_d = ST_FETCH;
                end else if (F == OP_JMP || F == OP_JGE || F == OP_JNE) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_EXEC && state_d == ST_HALT) begin
                halted_q  <= 1'b1;
                illegal_q <= is_illegal_op(F);
            end
        end
    end

    // Reset drops every request and enable combinationally in the reset cycle itself.
    assign ctrl_out = Reset ? '0 : ctrl;

    assign X_sel    = ctrl_out.x_sel;
    assign Y_sel    = ctrl_out.y_sel;
    assign Addr_sel = ctrl_out.addr_sel;
    assign PC_En    = ctrl_out.pc_en;
    assign IR_En    = ctrl_out.ir_en;
    assign Acc_En   = ctrl_out.acc_en;
    assign M        = ctrl_out.m;
    assign Rd       = ctrl_out.rd;
    assign Wr       = ctrl_out.wr;
    assign Halted   = halted_q;
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: one cycle per step, outputs compared against hand-built vectors.
module tb_mu0_control;

    logic       Clk;
    logic       Reset;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       Mem_Ack;
    logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
    logic [1:0] M;
    logic       Rd, Wr, Halted, Illegal;

    int checks   = 0;
    int failures = 0;

    logic [11:0] obs;
    assign obs = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted, Illegal};

    mu0_control dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .F        (F),
        .N        (N),
        .Z        (Z),
        .Mem_Ack  (Mem_Ack),
        .X_sel    (X_sel),
        .Y_sel    (Y_sel),
        .Addr_sel (Addr_sel),
        .PC_En    (PC_En),
        .IR_En    (IR_En),
        .Acc_En   (Acc_En),
        .M        (M),
        .Rd       (Rd),
        .Wr       (Wr),
        .Halted   (Halted),
        .Illegal  (Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [11:0] v(input logic xs, input logic ys, input logic as_,
                                      input logic pc, input logic ir, input logic acc,
                                      input logic [1:0] m, input logic rd, input logic wr,
                                      input logic h, input logic il);
        return {xs, ys, as_, pc, ir, acc, m, rd, wr, h, il};
    endfunction

    // Advance one rising edge, then apply this cycle's inputs.
    task automatic go(input logic rst, input logic [3:0] f, input logic n, input logic z,
                      input logic ack);
        @(posedge Clk);
        #1;
        Reset   = rst;
        F       = f;
        N       = n;
        Z       = z;
        Mem_Ack = ack;
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    logic [11:0] e_fetch, e_fetch_w, e_zero, e_halt, e_ill, e_lda, e_sta, e_add, e_subw;

    initial begin
        e_fetch   = v(1,0,0,1,1,0,2'b10,1,0,0,0);
        e_fetch_w = v(1,0,0,0,0,0,2'b10,1,0,0,0);
        e_zero    = v(0,0,0,0,0,0,2'b00,0,0,0,0);
        e_halt    = v(0,0,0,0,0,0,2'b00,0,0,1,0);
        e_ill     = v(0,0,0,0,0,0,2'b00,0,0,1,1);
        e_lda     = v(0,0,1,0,0,1,2'b00,1,0,0,0);
        e_sta     = v(0,0,1,0,0,0,2'b00,0,1,0,0);
        e_add     = v(0,0,1,0,0,1,2'b01,1,0,0,0);
        e_subw    = v(0,0,1,0,0,0,2'b11,1,0,0,0);

        Reset = 1'b1; F = 4'h0; N = 1'b0; Z = 1'b0; Mem_Ack = 1'b1;

        // reset
        go(1, 4'h0, 0, 0, 1);  chk("reset_outputs", e_zero);

        // LDA with immediate ack
        go(0, 4'h0, 0, 0, 1);  chk("lda_fetch", e_fetch);
        go(0, 4'h0, 0, 0, 1);  chk("lda_exec", e_lda);

        // STA with three wait cycles
        go(0, 4'h1, 0, 0, 1);  chk("sta_fetch", e_fetch);
        go(0, 4'h1, 0, 0, 0);  chk("sta_wait1", e_sta);
        go(0, 4'h1, 0, 0, 0);  chk("sta_wait2", e_sta);
        go(0, 4'h1, 0, 0, 0);  chk("sta_wait3", e_sta);
        go(0, 4'h1, 0, 0, 1);  chk("sta_ack", e_sta);

        // JGE not taken / taken, JNE not taken / taken
        go(0, 4'h5, 1, 0, 1);  chk("jge_fetch", e_fetch);
        go(0, 4'h5, 1, 0, 1);  chk("jge_n1", v(0,1,0,0,0,0,2'b00,0,0,0,0));
        go(0, 4'h5, 0, 0, 1);  chk("jge_back_fetch", e_fetch);
        go(0, 4'h5, 0, 0, 0);  chk("jge_n0", v(0,1,0,1,0,0,2'b00,0,0,0,0));
        go(0, 4'h6, 0, 1, 1);  chk("jne_fetch", e_fetch);
        go(0, 4'h6, 0, 1, 0);  chk("jne_z1", v(0,1,0,0,0,0,2'b00,0,0,0,0));
        go(0, 4'h6, 0, 0, 1);  chk("jne_back_fetch", e_fetch);
        go(0, 4'h6, 0, 0, 1);  chk("jne_z0", v(0,1,0,1,0,0,2'b00,0,0,0,0));
        go(0, 4'h4, 1, 1, 0);  chk("jmp_back_fetch_wait", e_fetch_w);

        // FETCH waiting two cycles, then ADD
        go(0, 4'h2, 0, 0, 0);  chk("fetch_wait2", e_fetch_w);
        go(0, 4'h2, 0, 0, 1);  chk("fetch_ack", e_fetch);
        go(0, 4'h2, 0, 0, 1);  chk("add_exec", e_add);

        // STP, then halt absorbs despite Mem_Ack toggling
        go(0, 4'h7, 0, 0, 1);  chk("stp_fetch", e_fetch);
        go(0, 4'h7, 0, 0, 1);  chk("stp_exec", e_zero);
        for (int i = 0; i < 10; i++) begin
            go(0, 4'(i), i[0], i[1], i[0]);
            chk($sformatf("halt_%0d", i), e_halt);
        end

        // illegal opcode
        go(1, 4'h0, 0, 0, 1);
        go(0, 4'h9, 0, 0, 1);  chk("ill_fetch_after_reset", e_fetch);
        go(0, 4'h9, 0, 0, 1);  chk("ill_exec", e_zero);
        go(0, 4'h9, 0, 0, 1);  chk("ill_halted", e_ill);
        go(0, 4'h0, 0, 0, 0);  chk("ill_absorbing", e_ill);

        // reset during SUB wait
        go(1, 4'h0, 0, 0, 1);
        go(0, 4'h3, 0, 0, 1);  chk("sub_fetch", e_fetch);
        go(0, 4'h3, 0, 0, 0);  chk("sub_wait1", e_subw);
        go(0, 4'h3, 0, 0, 0);  chk("sub_wait2", e_subw);
        go(1, 4'h3, 0, 0, 0);  chk("sub_reset_cycle", e_zero);
        go(0, 4'h3, 0, 0, 0);  chk("sub_after_reset", e_fetch_w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
